// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl
//   Multi-cycle MIPS control FSM. Each instruction is sequenced through
//   fetch, decode, execute, memory and write-back states. The FSM waits for
//   the memory ready handshake on every memory access. It drives the
//   datapath strobes and the ALU control code, flags undecodable
//   instructions and counts retired instructions.
//
//   Optional feature macro: CTRL_JUMP_EN
//     defined   : J/JAL are decoded and executed through the JMP state
//     undefined : J/JAL are reported as illegal; no JMP state exists
//
// Ports
//   clk          clock, all state updates on the rising edge
//   reset        synchronous, active-high; aborts any instruction in flight
//   op, funct    instruction fields IR[31:26] / IR[5:0]
//   mem_ready    memory completes the current mem_rd / mem_wr this cycle
//   pc_wr        unconditional PC write
//   pc_wr_cond   PC write when the ALU zero flag is set
//   npc_sel      next PC source: 00 ALU result, 01 branch target, 10 jump target
//   i_or_d       memory address: 0 PC, 1 ALU out register
//   mem_rd       memory read request
//   mem_wr       memory write request
//   ir_wr        instruction register load
//   reg_wr       register file write
//   reg_dst      destination register: 00 rt, 01 rd, 10 r31
//   mem_to_reg   write-back data: 00 ALU out, 01 MDR, 10 PC
//   alu_src_a    ALU A operand: 0 PC, 1 rs
//   alu_src_b    ALU B operand: 00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2
//   ext_op       immediate extension: 1 sign, 0 zero
//   alu_ctr      ALU operation code
//   illegal      one-cycle pulse on an undecodable instruction
//   retire       one-cycle pulse on the last cycle of each legal instruction
//   retired_cnt  retired-instruction counter, wraps
module multi_cycle_ctrl #(
    parameter int               ALU_W   = 3,
    parameter logic [ALU_W-1:0] ALU_ADD = 3'b000,
    parameter logic [ALU_W-1:0] ALU_SUB = 3'b001,
    parameter logic [ALU_W-1:0] ALU_ORI = 3'b010,
    parameter logic [ALU_W-1:0] ALU_LUI = 3'b011,
    parameter int               CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    output logic             pc_wr,
    output logic             pc_wr_cond,
    output logic [1:0]       npc_sel,
    output logic             i_or_d,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             ir_wr,
    output logic             reg_wr,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             ext_op,
    output logic [ALU_W-1:0] alu_ctr,
    output logic             illegal,
    output logic             retire,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
`ifdef CTRL_JUMP_EN
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
`endif
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        FETCH, DECODE, MADDR, MRD, LWB, MWR, EXR, RWB, EXI, IWB, BR
`ifdef CTRL_JUMP_EN
        , JMP
`endif
    } ctrlState_t;

    ctrlState_t state;
    ctrlState_t dispatchState;
    logic       decodeIllegal;

    // Instruction dispatch out of DECODE; anything unmatched is illegal.
    always_comb begin
        dispatchState = FETCH;
        decodeIllegal = 1'b1;
        case (op)
            OP_LW, OP_SW: begin
                dispatchState = MADDR;
                decodeIllegal = 1'b0;
            end
            OP_R: begin
                if (funct == FN_ADDU || funct == FN_SUBU) begin
                    dispatchState = EXR;
                    decodeIllegal = 1'b0;
                end
            end
            OP_ORI, OP_LUI: begin
                dispatchState = EXI;
                decodeIllegal = 1'b0;
            end
            OP_BEQ: begin
                dispatchState = BR;
                decodeIllegal = 1'b0;
            end
`ifdef CTRL_JUMP_EN
            OP_J, OP_JAL: begin
                dispatchState = JMP;
                decodeIllegal = 1'b0;
            end
`endif
            default: ;
        endcase
    end

    // Moore strobes decoded from state. The FETCH handshake strobes and
    // the MWR retire also follow mem_ready. Everything is forced low while
    // reset is asserted so an aborted instruction cannot write anything.
    always_comb begin
        pc_wr      = 1'b0;
        pc_wr_cond = 1'b0;
        npc_sel    = 2'b00;
        i_or_d     = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        ir_wr      = 1'b0;
        reg_wr     = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        ext_op     = 1'b0;
        alu_ctr    = ALU_ADD;
        illegal    = 1'b0;
        retire     = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    mem_rd    = 1'b1;
                    alu_src_b = 2'b01;
                    ir_wr     = mem_ready;
                    pc_wr     = mem_ready;
                end
                DECODE: begin
                    alu_src_b = 2'b11;
                    ext_op    = 1'b1;
                    illegal   = decodeIllegal;
                end
                MADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    ext_op    = 1'b1;
                end
                MRD: begin
                    mem_rd = 1'b1;
                    i_or_d = 1'b1;
                end
                LWB: begin
                    reg_wr     = 1'b1;
                    mem_to_reg = 2'b01;
                    retire     = 1'b1;
                end
                MWR: begin
                    mem_wr = 1'b1;
                    i_or_d = 1'b1;
                    retire = mem_ready;
                end
                EXR: begin
                    alu_src_a = 1'b1;
                    alu_ctr   = (funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
                end
                RWB: begin
                    reg_wr  = 1'b1;
                    reg_dst = 2'b01;
                    retire  = 1'b1;
                end
                EXI: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_ctr   = (op == OP_LUI) ? ALU_LUI : ALU_ORI;
                end
                IWB: begin
                    reg_wr = 1'b1;
                    retire = 1'b1;
                end
                BR: begin
                    alu_src_a  = 1'b1;
                    alu_ctr    = ALU_SUB;
                    pc_wr_cond = 1'b1;
                    npc_sel    = 2'b01;
                    retire     = 1'b1;
                end
`ifdef CTRL_JUMP_EN
                JMP: begin
                    pc_wr   = 1'b1;
                    npc_sel = 2'b10;
                    retire  = 1'b1;
                    if (op == OP_JAL) begin
                        reg_wr     = 1'b1;
                        reg_dst    = 2'b10;
                        mem_to_reg = 2'b10;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // State register and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            retired_cnt <= '0;
        end else begin
            if (retire) begin
                retired_cnt <= retired_cnt + CNT_ONE;
            end
            case (state)
                FETCH:  if (mem_ready) state <= DECODE;
                DECODE: state <= dispatchState;
                MADDR:  state <= (op == OP_SW) ? MWR : MRD;
                MRD:    if (mem_ready) state <= LWB;
                MWR:    if (mem_ready) state <= FETCH;
                EXR:    state <= RWB;
                EXI:    state <= IWB;
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
module tb_multi_cycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       mem_ready;
    logic       pc_wr, pc_wr_cond, i_or_d, mem_rd, mem_wr, ir_wr, reg_wr;
    logic [1:0] npc_sel, reg_dst, mem_to_reg, alu_src_b;
    logic       alu_src_a, ext_op, illegal, retire;
    logic [2:0] alu_ctr;
    logic [1:0] retired_cnt;

    multi_cycle_ctrl #(.CNT_W(2)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .mem_ready(mem_ready),
        .pc_wr(pc_wr), .pc_wr_cond(pc_wr_cond), .npc_sel(npc_sel), .i_or_d(i_or_d),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .ir_wr(ir_wr), .reg_wr(reg_wr),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .ext_op(ext_op), .alu_ctr(alu_ctr),
        .illegal(illegal), .retire(retire), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    // Strobe vector compared on the last cycle of each instruction.
    logic [12:0] curVec;
    logic [21:0] allOut;
    assign curVec = {pc_wr, pc_wr_cond, npc_sel, i_or_d, mem_rd, mem_wr, ir_wr,
                     reg_wr, reg_dst, mem_to_reg};
    assign allOut = {curVec, alu_src_a, alu_src_b, ext_op, alu_ctr, illegal, retire};

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  funct;
        int          fetchWait;
        int          memWait;
        int          lat;
        logic        legal;
        logic [12:0] lastVec;
        logic [2:0]  alu2;
        logic [2:0]  src2;
    } vec_t;

    typedef struct packed {
        int          lat;
        logic        legal;
        logic [12:0] lastVec;
        logic        chkExec;
        logic [2:0]  alu2;
        logic [2:0]  src2;
        logic [1:0]  cnt;
    } exp_t;

    vec_t tbl[16];
    int   nVec = 0;
    exp_t sb[$];
    logic [1:0] modelCnt = 2'd0;
    int   total = 0;
    int   bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, want);
        end
    endtask

    function automatic logic [12:0] sv(input logic pcw, input logic pcc, input logic [1:0] npc,
                                       input logic iod, input logic mrd, input logic mwr,
                                       input logic irw, input logic rw, input logic [1:0] rd,
                                       input logic [1:0] mtr);
        return {pcw, pcc, npc, iod, mrd, mwr, irw, rw, rd, mtr};
    endfunction

    task automatic addV(input logic [5:0] o, input logic [5:0] f, input int fw, input int mw,
                        input int lat, input logic legal, input logic [12:0] lv,
                        input logic [2:0] a2, input logic [2:0] s2);
        vec_t v;
        v.op = o; v.funct = f; v.fetchWait = fw; v.memWait = mw; v.lat = lat;
        v.legal = legal; v.lastVec = lv; v.alu2 = a2; v.src2 = s2;
        tbl[nVec] = v;
        nVec++;
    endtask

    // Runs one instruction starting at a falling edge with the FSM in FETCH.
    task automatic runInstr(input vec_t v, input int idx);
        exp_t e, g;
        int cycles, fw, mw;
        bit done;
        logic [2:0] a2, s2;
        logic [12:0] lv;
        logic gr, gi;
        if (v.legal) modelCnt = modelCnt + 2'd1;
        e.lat = v.lat; e.legal = v.legal; e.lastVec = v.lastVec;
        e.chkExec = ((v.lat - v.fetchWait) >= 3); e.alu2 = v.alu2; e.src2 = v.src2;
        e.cnt = modelCnt;
        sb.push_back(e);
        op = v.op; funct = v.funct; fw = v.fetchWait; mw = v.memWait;
        cycles = 0; done = 0; a2 = 0; s2 = 0; lv = 0; gr = 0; gi = 0;
        while (!done && cycles < 40) begin
            if (mem_rd && !i_or_d) begin
                if (fw > 0) begin mem_ready = 1'b0; fw--; end
                else mem_ready = 1'b1;
            end else if ((mem_rd && i_or_d) || mem_wr) begin
                if (mw > 0) begin mem_ready = 1'b0; mw--; end
                else mem_ready = 1'b1;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            if (cycles == v.fetchWait + 2) begin
                a2 = alu_ctr;
                s2 = {alu_src_a, alu_src_b};
            end
            cycles++;
            if (retire || illegal) begin
                done = 1; lv = curVec; gr = retire; gi = illegal;
            end
            @(negedge clk);
        end
        g = sb.pop_front();
        check($sformatf("v%0d_done", idx), 32'(done), 32'd1);
        check($sformatf("v%0d_latency", idx), 32'(cycles), 32'(g.lat));
        check($sformatf("v%0d_retire", idx), 32'(gr), 32'(g.legal));
        check($sformatf("v%0d_illegal", idx), 32'(gi), 32'(!g.legal));
        check($sformatf("v%0d_laststrobes", idx), 32'(lv), 32'(g.lastVec));
        if (g.chkExec) begin
            check($sformatf("v%0d_exec_alu", idx), 32'(a2), 32'(g.alu2));
            check($sformatf("v%0d_exec_src", idx), 32'(s2), 32'(g.src2));
        end
        check($sformatf("v%0d_cnt", idx), 32'(retired_cnt), 32'(g.cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        // op, funct, fetchWait, memWait, latency, legal, last-cycle strobes, exec alu, exec {a,b}
        addV(6'b000000, 6'b100001, 0, 0, 4, 1, sv(0,0,2'b00,0,0,0,0,1,2'b01,2'b00), 3'b000, 3'b100);
        addV(6'b000000, 6'b100011, 0, 0, 4, 1, sv(0,0,2'b00,0,0,0,0,1,2'b01,2'b00), 3'b001, 3'b100);
        addV(6'b001101, 6'b000000, 0, 0, 4, 1, sv(0,0,2'b00,0,0,0,0,1,2'b00,2'b00), 3'b010, 3'b110);
        addV(6'b001111, 6'b000000, 0, 0, 4, 1, sv(0,0,2'b00,0,0,0,0,1,2'b00,2'b00), 3'b011, 3'b110);
        addV(6'b100011, 6'b000000, 0, 0, 5, 1, sv(0,0,2'b00,0,0,0,0,1,2'b00,2'b01), 3'b000, 3'b110);
        addV(6'b100011, 6'b000000, 0, 3, 8, 1, sv(0,0,2'b00,0,0,0,0,1,2'b00,2'b01), 3'b000, 3'b110);
        addV(6'b101011, 6'b000000, 0, 0, 4, 1, sv(0,0,2'b00,1,0,1,0,0,2'b00,2'b00), 3'b000, 3'b110);
        addV(6'b101011, 6'b000000, 0, 2, 6, 1, sv(0,0,2'b00,1,0,1,0,0,2'b00,2'b00), 3'b000, 3'b110);
        addV(6'b000100, 6'b000000, 0, 0, 3, 1, sv(0,1,2'b01,0,0,0,0,0,2'b00,2'b00), 3'b001, 3'b100);
        addV(6'b111111, 6'b000000, 0, 0, 2, 0, 13'd0, 3'b000, 3'b000);
        addV(6'b000000, 6'b000000, 0, 0, 2, 0, 13'd0, 3'b000, 3'b000);
        addV(6'b000000, 6'b100001, 2, 0, 6, 1, sv(0,0,2'b00,0,0,0,0,1,2'b01,2'b00), 3'b000, 3'b100);
`ifdef CTRL_JUMP_EN
        addV(6'b000010, 6'b000000, 0, 0, 3, 1, sv(1,0,2'b10,0,0,0,0,0,2'b00,2'b00), 3'b000, 3'b000);
        addV(6'b000011, 6'b000000, 0, 0, 3, 1, sv(1,0,2'b10,0,0,0,0,1,2'b10,2'b10), 3'b000, 3'b000);
`else
        addV(6'b000010, 6'b000000, 0, 0, 2, 0, 13'd0, 3'b000, 3'b000);
        addV(6'b000011, 6'b000000, 0, 0, 2, 0, 13'd0, 3'b000, 3'b000);
`endif
        addV(6'b001101, 6'b000000, 0, 0, 4, 1, sv(0,0,2'b00,0,0,0,0,1,2'b00,2'b00), 3'b010, 3'b110);

        // Power-on reset held two cycles.
        reset = 1'b1; op = 6'd0; funct = 6'd0; mem_ready = 1'b1;
        @(negedge clk);
        #1;
        check("reset_outputs_zero", 32'(allOut), 32'd0);
        @(negedge clk);
        reset = 1'b0; mem_ready = 1'b0;
        #1;
        check("post_reset_mem_rd", 32'(mem_rd), 32'd1);
        check("post_reset_i_or_d", 32'(i_or_d), 32'd0);
        check("post_reset_src_b", 32'(alu_src_b), 32'd1);
        check("post_reset_ir_wr_stalled", 32'(ir_wr), 32'd0);
        check("post_reset_cnt", 32'(retired_cnt), 32'd0);
        @(negedge clk);

        for (int i = 0; i < nVec; i++) begin
            runInstr(tbl[i], i);
        end

        // Reset asserted while a load waits in its memory read state.
        op = 6'b100011; funct = 6'd0; found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            mem_ready = 1'b1;
            #1;
            if (mem_rd && i_or_d) found = 1;
        end
        mem_ready = 1'b0;
        check("mrd_reached", 32'(found), 32'd1);
        check("pre_reset_cnt", 32'(retired_cnt), 32'(modelCnt));
        reset = 1'b1;
        #1;
        check("mid_reset_outputs_zero", 32'(allOut), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        modelCnt = 2'd0;
        check("abort_fetch_mem_rd", 32'(mem_rd), 32'd1);
        check("abort_fetch_i_or_d", 32'(i_or_d), 32'd0);
        check("abort_cnt_cleared", 32'(retired_cnt), 32'd0);
        check("abort_no_retire", 32'(retire), 32'd0);
        @(negedge clk);
        runInstr(tbl[0], 99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
